// File: rtl/uart_tx_param.sv
// uart_tx_param: UART transmitter with a small input FIFO.
// Frames are start / DATA_BITS data (LSB first) / optional parity / STOP_BITS stop.
// The serial line is registered. Its next value is derived from the next state,
// so every bit lasts exactly CLKS_PER_BIT cycles.
//
// Handshake: a byte is taken on any rising edge where tx_valid && tx_ready.
// tx_ready is derived from the registered FIFO count, so it is 0 whenever the
// FIFO holds FIFO_DEPTH entries. This holds even on a cycle where the engine
// pops. tx_valid while tx_ready is 0 has no effect. tx_data need not be held
// after acceptance.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                             sysclk,
  input  logic                             reset,
  input  logic [DATA_BITS-1:0]             tx_data,
  input  logic                             tx_valid,
  output logic                             tx_ready,
  output logic                             tx_line,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [NW-1:0] FIFO_FULL = NW'(FIFO_DEPTH);
  localparam logic          ODD_PAR   = (PARITY == 1);
  localparam logic          HAS_PAR   = (PARITY != 0);

  // FSM state lives in state_q so checkers can bind to it directly.
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 line_q, line_d;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        rd_ptr_q, wr_ptr_q;
  logic [NW-1:0]        count_q;
  logic                 push, pop, fifo_empty, bit_end;
  logic [DATA_BITS-1:0] head;

  assign fifo_empty = (count_q == '0);
  assign tx_ready   = (count_q < FIFO_FULL);
  assign push       = tx_valid && tx_ready;
  assign head       = mem[rd_ptr_q];
  assign bit_end    = (baud_q == BAUD_LAST);

  assign tx_line    = line_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;

  // Next-state, baud/bit counters, frame loading and next line value.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    pop     = 1'b0;
    line_d  = 1'b1;

    if (state_q != ST_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = head;
          par_d   = (^head) ^ ODD_PAR;
          bit_d   = '0;
          baud_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = HAS_PAR ? ST_PAR : ST_STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q >> 1;
          end
        end
      end
      ST_PAR: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            // Chain straight into the next start bit when data is waiting.
            if (!fifo_empty) begin
              pop     = 1'b1;
              shreg_d = head;
              par_d   = (^head) ^ ODD_PAR;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START: line_d = 1'b0;
      ST_DATA:  line_d = shreg_d[0];
      ST_PAR:   line_d = par_d;
      default:  line_d = 1'b1;
    endcase
  end

  // Transmit engine registers; reset abandons any partial frame.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      line_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      line_q  <= line_d;
    end
  end

  // FIFO storage; contents need no reset because the count gates every read.
  always_ff @(posedge sysclk) begin
    if (push) begin
      mem[wr_ptr_q] <= tx_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter with a small input FIFO, the synthesizable successor to the hand-timed serial stimulus used in CPU benches. Bytes are pushed over a valid/ready handshake and serialised as start/data/parity/stop frames at a configurable bit period. It can drive `UART_RX` of `Pipeline` in simulation, and it serves as the CPU's on-chip `UART_TX` engine.

## Interface
Parameters:
- `CLKS_PER_BIT`, 5208, clock cycles per serial bit (50 MHz / 9600 baud); legal range ≥2.
- `DATA_BITS`, 8, data bits per frame; legal range 5..9.
- `PARITY`, 0, parity mode: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1, stop bits per frame: 1 or 2.
- `FIFO_DEPTH`, 4, input FIFO entries; power of two, ≥2.

Ports:
- `sysclk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tx_data`  in  DATA_BITS  byte to send.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  FIFO can accept (`!full`).
- `tx_line`  out  1  serial output; idle high.
- `busy`  out  1  frame in progress or FIFO non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH+1)  occupied FIFO entries.

## Operation
- Push: on an edge with `tx_valid && tx_ready`, `tx_data` is written to the FIFO tail. When `tx_ready` is 0, `tx_valid` is ignored and data is dropped with no side effects.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: `tx_line`=1. If the FIFO is non-empty, pop the head into the shift register, clear the bit counter, and go to START.
  - START: `tx_line`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: shift LSB first, one bit per CLKS_PER_BIT cycles, DATA_BITS bits. After the last bit, go to PAR if PARITY≠0, otherwise go to STOP.
  - PAR: the parity bit is XOR of the data bits (even) or its complement (odd). It lasts one bit period.
  - STOP: `tx_line`=1 for STOP_BITS×CLKS_PER_BIT cycles. On the last cycle, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, resets at every bit boundary, and wraps with no drift.
- `tx_line` is registered and glitch-free.
- `busy` = (state≠IDLE) || (fifo_count≠0).
- FIFO: circular buffer with read/write pointers of width $clog2(FIFO_DEPTH) that wrap modulo depth.
  - `fifo_count` +1 on push only, −1 on pop only, unchanged when push and pop occur on the same edge.
  - `tx_ready` = (fifo_count < FIFO_DEPTH), from registered count. When the FIFO is full, a push coinciding with a pop is still refused (no pass-through).
- Reset: asserting `reset` low at any time, including mid-frame, immediately forces:
  - `tx_line`=1, state IDLE, FIFO flushed, counters cleared;
  - `busy`=0, `fifo_count`=0, `tx_ready`=1.
  - The partial frame is abandoned.

## Timing
- Reset values: `tx_line`=1, `tx_ready`=1, `busy`=0, `fifo_count`=0.
- Latency: push at edge N into an empty FIFO while IDLE → `tx_line` falls after edge N+1. `busy` rises after edge N.
- Frame length is (1+DATA_BITS+(PARITY≠0)+STOP_BITS)×CLKS_PER_BIT cycles exactly. Example: 10×5208 = 52080 cycles = 1.0416 ms at 50 MHz for 8N1.
- Back-to-back frames: the next start bit begins on the cycle immediately after the final stop-bit cycle.
- `fifo_count` updates on the same edge as the push/pop that changes it. `tx_ready` falls on the edge after the push that fills the FIFO.

## Test plan
Benches use CLKS_PER_BIT=4 unless noted.
- 8N1, push 0x18 once: `tx_line` reads 0,0,0,0,1,1,0,0,0,1 (start, LSB first, stop), 4 cycles each. Line goes low 1 cycle after accept. `busy` falls after 40 cycles plus 1.
- Push 0x18 then 0x78 on consecutive cycles: frames are contiguous (80 cycles low-to-idle, no gap). Second data reads 0,0,0,1,1,1,1,0.
- FIFO_DEPTH=4, hold `tx_valid` high with 0x01..0x06 while the first frame sends: `fifo_count` peaks at 4 and `tx_ready`=0. The 0x06 offered while full is dropped. Output order is 0x01..0x05 plus whichever values are accepted after pops, with no duplicates.
- PARITY=2, STOP_BITS=2, push 0x07: the parity bit is 1 (three ones) and the line stays high for 8 stop cycles. With PARITY=1, same byte: the parity bit is 0.
- Assert `reset` low mid-DATA with 2 bytes queued: `tx_line`=1, `fifo_count`=0, `busy`=0 asynchronously. After release, a push of 0x55 sends a clean frame.
- CLKS_PER_BIT=5208 at 20 ns clock, 8N1, push 0x18: each bit lasts 104160 ns. Feeding `Pipeline` `UART_RX`, the CPU receives 0x18 (24).
